psf_symbol_scheduler: RTL
=========================

Name: psf_symbol_scheduler

Overview:
Sequences symbol frames into the pulse-shaping filter at the 8 MHz sample clock.
- Accepts one bit per symbol through a valid/ready handshake and maps it to ±1.
- Performs zero-insertion upsampling by OSR and drives the filter's 2-bit signed input.
- After the last symbol, flushes the filter with zeros and flags which filter output samples belong to the frame.

Parameters:
OSR, 8, upsampling factor (samples per symbol); legal range 2..16.
FLUSH_LEN, 33, zero samples driven after the last symbol (filter tap count).
FILT_LAT, 4, cycles from usp_data change to the corresponding filtered_data sample.
LEN_W, 16, width of frame length field.

Ports:
clk_8megahz  input  1  sample clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle frame start request; sampled only in IDLE.
frame_len  input  LEN_W  symbols in frame; captured on accepted start.
sym_valid  input  1  symbol source has a bit available.
sym_bit  input  1  symbol bit: 1 -> +1, 0 -> -1.
sym_ready  output  1  scheduler consumes sym_bit this cycle.
usp_data  output  2 signed  upsampled sample to filter (01=+1, 11=-1, 00=0).
filt_valid  output  1  filtered_data sample this cycle belongs to the active frame.
busy  output  1  high in RUN and FLUSH.
done  output  1  one-cycle pulse at end of frame.
underrun  output  1  one-cycle pulse when a symbol slot found no symbol.

Behaviour:
- Reset: all outputs 0; state IDLE; phase, symbol and flush counters 0; filt_valid shift register cleared. Reset mid-frame aborts immediately with no done pulse.
- All outputs are registered. usp_data is 0 whenever the state is not RUN.
- IDLE:
  - start=1 with frame_len≠0: capture frame_len, phase=0, go to RUN.
  - start=1 with frame_len=0: go to DONE.
  - start is ignored in every other state.
- RUN: phase counts 0..OSR-1 and wraps to 0.
  - sym_ready is combinational and equals (state==RUN && phase==0 && sym_valid && symbols_left≠0).
  - Phase 0 with sym_valid=1: consume the bit; the next-cycle usp_data is +1/-1; symbols_left decrements.
  - Phase 0 with sym_valid=0: usp_data=0 for the slot; underrun pulses next cycle; the slot still counts as a symbol (frame timing is fixed).
  - Phases 1..OSR-1: usp_data=0.
  - When symbols_left=0 and phase==OSR-1, go to FLUSH. The last symbol therefore always gets its full OSR-sample slot.
- FLUSH: drive 0 for exactly FLUSH_LEN cycles (counter FLUSH_LEN-1 down to 0), then go to DONE.
- DONE: done=1 for one cycle, then IDLE. A start in the DONE cycle is ignored.
- filt_valid: active flag = (state was RUN or FLUSH in the cycle usp_data was registered), delayed by FILT_LAT registers. Total asserted cycles per frame = frame_len*OSR + FLUSH_LEN.
- busy: 1 in RUN and FLUSH, 0 in IDLE and DONE.
- Counter widths: phase is ceil(log2(OSR)); symbols_left is LEN_W; no counter wraps beyond its legal range.

Optional Feature:
PSF_ABORT_EN.
- Defined: adds input port abort (1 bit).
  - abort=1 in RUN: go to FLUSH next cycle regardless of phase and symbols left; the current slot is truncated; no further sym_ready.
  - abort in FLUSH, IDLE or DONE has no effect.
  - The frame still ends with a flush and a done pulse.
- Not defined: port absent; a frame always runs to completion.

Test Plan:
- Reset hold with random inputs -> all outputs 0; release with start=0 -> remains IDLE, usp_data=0.
- start, frame_len=3, sym_valid=1 constant, bits 1,0,1 -> usp_data pattern +1,0×7,-1,0×7,+1,0×7, then 33 zeros; sym_ready high on exactly 3 cycles; done 1 cycle after flush; filt_valid high for 57 cycles starting 4 cycles after the first +1.
- frame_len=2, sym_valid low at the second slot -> underrun pulses once; usp_data stays 0 for that slot; frame still ends after 16+33 cycles with done.
- frame_len=0 with start -> no RUN or FLUSH; done pulses once; filt_valid never asserts.
- start asserted during RUN and in the DONE cycle -> ignored, no second frame; rst_n low mid-RUN -> outputs 0 immediately, no done pulse.
- With PSF_ABORT_EN, frame_len=10, abort at phase 3 of symbol 2 -> FLUSH next cycle, 33 zeros, done, sym_ready count=2.

Source files
------------

// File: rtl/psf_symbol_scheduler.sv
// Symbol-to-PSF sequencer: 1-bit symbols -> +/-1, OSR zero-stuffing, FLUSH_LEN-zero flush, framed filt_valid; PSF_ABORT_EN adds abort.
// Latency: usp_data 1 cycle after symbol accept, filt_valid FILT_LAT later; backpressure: sym_ready only at slot phase 0, a missing symbol leaves a zero slot.
module psf_symbol_scheduler #(
  parameter int OSR       = 8,
  parameter int FLUSH_LEN = 33,
  parameter int FILT_LAT  = 4,
  parameter int LEN_W     = 16
) (
  input  logic              clk_8megahz,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic              sym_valid,
  input  logic              sym_bit,
`ifdef PSF_ABORT_EN
  input  logic              abort,
`endif
  output logic              sym_ready,
  output logic signed [1:0] usp_data,
  output logic              filt_valid,
  output logic              busy,
  output logic              done,
  output logic              underrun
);

  localparam int PH_W = $clog2(OSR);
  localparam int FL_W = $clog2(FLUSH_LEN + 1);
  localparam logic [PH_W-1:0] PH_LAST    = PH_W'(OSR - 1);
  localparam logic [FL_W-1:0] FLUSH_LOAD = FL_W'(FLUSH_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [LEN_W-1:0]  sym_left_q, sym_left_d;
  logic [FL_W-1:0]   flush_q, flush_d;
  logic signed [1:0] usp_q, usp_d;
  logic [FILT_LAT:0] fv_sr_q, fv_sr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              underrun_q, underrun_d;
  logic              act_d;
  logic              abort_w;

`ifdef PSF_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    sym_left_d = sym_left_q;
    flush_d    = flush_q;
    usp_d      = 2'sb00;
    underrun_d = 1'b0;
    sym_ready  = 1'b0;
    act_d      = (state_q == S_RUN) || (state_q == S_FLUSH);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (frame_len != '0) begin
            sym_left_d = frame_len;
            phase_d    = '0;
            state_d    = S_RUN;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (abort_w) begin
          // Truncate the current slot; the frame still drains through the filter.
          phase_d = '0;
          flush_d = FLUSH_LOAD;
          state_d = S_FLUSH;
        end else begin
          if (phase_q == '0 && sym_left_q != '0) begin
            sym_left_d = sym_left_q - 1'b1;
            if (sym_valid) begin
              sym_ready = 1'b1;
              usp_d     = sym_bit ? 2'sb01 : 2'sb11;
            end else begin
              underrun_d = 1'b1;
            end
          end
          if (phase_q == PH_LAST) begin
            phase_d = '0;
            if (sym_left_q == '0) begin
              flush_d = FLUSH_LOAD;
              state_d = S_FLUSH;
            end
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end
      S_FLUSH: begin
        if (flush_q == '0) begin
          state_d = S_DONE;
        end else begin
          flush_d = flush_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d  = (state_d == S_RUN) || (state_d == S_FLUSH);
    done_d  = (state_d == S_DONE);
    // Stage 0 lines up with usp_data; the top stage lines up with filtered_data.
    fv_sr_d = {fv_sr_q[FILT_LAT-1:0], act_d};
  end

  always_ff @(posedge clk_8megahz or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      sym_left_q <= '0;
      flush_q    <= '0;
      usp_q      <= 2'sb00;
      fv_sr_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      sym_left_q <= sym_left_d;
      flush_q    <= flush_d;
      usp_q      <= usp_d;
      fv_sr_q    <= fv_sr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
    end
  end

  assign usp_data   = usp_q;
  assign filt_valid = fv_sr_q[FILT_LAT];
  assign busy       = busy_q;
  assign done       = done_q;
  assign underrun   = underrun_q;

endmodule
